// File: rtl/riscv_pkg.sv
// Shared RV32 encodings for the multi-cycle sequencer: opcodes, ALUOp codes,
// FSM states and the packed control bundle driven toward the datapath.
package riscv_pkg;

  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_I       = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BR     = 2'b01;
  localparam logic [1:0] ALU_FUNC   = 2'b10;
  localparam logic [1:0] ALU_CUSTOM = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       jump;
    logic       ir_write;
    logic       ior_d;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

  function automatic logic is_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_CUSTOM0: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_decode_rom.sv
// Combinational control ROM: maps (state, latched opcode/func3, mem_ready)
// onto the datapath control bundle. Holds no state of its own.
module mc_decode_rom
  import riscv_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b0;
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
      end
      S_EXEC: begin
        case (op)
          OP_R: begin
            ctrl.alu_op  = ALU_FUNC;
            ctrl.alu_src = 1'b0;
          end
          OP_I: begin
            // addi is a plain add; every other I-type op goes through func3
            ctrl.alu_op  = (f3 == 3'b000) ? ALU_ADD : ALU_FUNC;
            ctrl.alu_src = 1'b1;
          end
          OP_CUSTOM0: begin
            ctrl.alu_op  = ALU_CUSTOM;
            ctrl.alu_src = 1'b0;
          end
          OP_LOAD, OP_STORE, OP_JAL: begin
            ctrl.alu_op  = ALU_ADD;
            ctrl.alu_src = 1'b1;
          end
          OP_BRANCH: begin
            ctrl.branch        = 1'b1;
            ctrl.alu_op        = ALU_BR;
            ctrl.alu_src       = 1'b0;
            ctrl.pc_write_cond = 1'b1;
          end
          default: ctrl = '0;
        endcase
      end
      S_MEM: begin
        ctrl.ior_d     = 1'b1;
        ctrl.mem_read  = (op == OP_LOAD);
        ctrl.mem_write = (op == OP_STORE);
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = (op == OP_LOAD);
        ctrl.jump       = (op == OP_JAL);
        ctrl.pc_write   = (op == OP_JAL);
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/MEM/WB state machine with a
// custom-0 latency counter, retired-instruction counter and sticky illegal flag.
module multicycle_control
  import riscv_pkg::*;
#(
  parameter int CUSTOM_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             pcWrite,
  output logic             pcWriteCond,
  output logic             jump,
  output logic             irWrite,
  output logic             iorD,
  output logic             branch,
  output logic             memRead,
  output logic             memWrite,
  output logic             memtoReg,
  output logic [1:0]       ALUOp,
  output logic             ALUSrc,
  output logic             regWrite,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  // Memory handshake: an access is presented (memRead/memWrite, iorD) for as
  // long as the FSM sits in FETCH or MEM; it completes on the first cycle
  // mem_ready is high, and the FSM advances on that clock edge. mem_ready is
  // ignored in every other state.

  localparam logic [3:0] CUST_INIT = 4'(CUSTOM_LAT - 1);

  state_t           state;
  state_t           state_next;
  logic [6:0]       op_q;
  logic [2:0]       f3_q;
  logic [3:0]       cust_cnt;
  logic             illegal_q;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  ctrl_t            rom_ctrl;
  ctrl_t            ctrl;

  // zero is consumed by the datapath's branch gating, not by the sequencer
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      op_q      <= '0;
      f3_q      <= '0;
      cust_cnt  <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        op_q <= opcode;
        f3_q <= func3;
      end
      if (state == S_DECODE && state_next == S_EXEC) begin
        cust_cnt <= (opcode == OP_CUSTOM0) ? CUST_INIT : 4'd0;
      end else if (state == S_EXEC && cust_cnt != 4'd0) begin
        cust_cnt <= cust_cnt - 4'd1;
      end
      if (state_next == S_TRAP) begin
        illegal_q <= 1'b1;
      end
      if (retire) begin
        instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        state_next = is_legal(opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (op_q)
          OP_LOAD, OP_STORE: state_next = S_MEM;
          OP_BRANCH: begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end
          // custom-0 stays in EXEC until its latency counter drains
          OP_CUSTOM0: begin
            if (cust_cnt == 4'd0) state_next = S_WB;
          end
          default: state_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_LOAD) begin
            state_next = S_WB;
          end else begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end
        end
      end
      S_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  mc_decode_rom u_rom (
    .state     (state),
    .op        (op_q),
    .f3        (f3_q),
    .mem_ready (mem_ready),
    .ctrl      (rom_ctrl)
  );

  // Reset overrides every control line immediately, not only after the edge
  assign ctrl = rst ? '0 : rom_ctrl;

  assign pcWrite     = ctrl.pc_write;
  assign pcWriteCond = ctrl.pc_write_cond;
  assign jump        = ctrl.jump;
  assign irWrite     = ctrl.ir_write;
  assign iorD        = ctrl.ior_d;
  assign branch      = ctrl.branch;
  assign memRead     = ctrl.mem_read;
  assign memWrite    = ctrl.mem_write;
  assign memtoReg    = ctrl.mem_to_reg;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrc      = ctrl.alu_src;
  assign regWrite    = ctrl.reg_write;
  assign illegal     = illegal_q & ~rst;
  assign instret     = instret_q;

endmodule
